// File: rtl/br_resolve_arb_pkg.sv
// Shared types for the branch-resolution arbiter: tag width, pending-table entry and FSM states.
package br_resolve_arb_pkg;

  localparam int unsigned BR_MASK_W = 5;

  typedef logic [BR_MASK_W-1:0] br_tag_t;

  typedef struct packed {
    logic    valid;
    logic    mispred;
    br_tag_t mask;
  } br_pend_entry_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } br_arb_state_e;

endpackage

// File: rtl/br_oldest_sel.sv
// Picks the oldest pending mispredict: the one whose mask names no other pending mispredict.
module br_oldest_sel
  import br_resolve_arb_pkg::*;
(
  input  br_tag_t                 valid_i,
  input  br_tag_t                 mispred_i,
  input  br_tag_t [BR_MASK_W-1:0] mask_i,
  output logic                    found_o,
  output br_tag_t                 sel_o
);

  br_tag_t cand;

  assign cand = valid_i & mispred_i;

  always_comb begin
    found_o = 1'b0;
    sel_o   = '0;
    for (int unsigned i = 0; i < BR_MASK_W; i++) begin
      if (cand[i] && !found_o && ((mask_i[i] & cand) == '0)) begin
        found_o  = 1'b1;
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/br_resolve_arb.sv
// Serialises execute-stage branch resolutions into one correct/recovery event per cycle.
// Tag width comes from br_resolve_arb_pkg::BR_MASK_W.
module br_resolve_arb
  import br_resolve_arb_pkg::*;
#(
  parameter int unsigned NUM_BR_PORTS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BR_PORTS-1:0]           ex_br_valid_i,
  input  logic [NUM_BR_PORTS*BR_MASK_W-1:0] ex_br_tag_i,
  input  logic [NUM_BR_PORTS*BR_MASK_W-1:0] ex_br_mask_i,
  input  logic [NUM_BR_PORTS-1:0]           ex_br_mispred_i,
  output logic                              rob_br_pred_correct_o,
  output logic                              rob_br_recovery_o,
  output logic [BR_MASK_W-1:0]              rob_br_tag_o,
  output logic [BR_MASK_W-1:0]              rob_br_mask_o,
  output logic                              arb_busy_o
);

  br_pend_entry_t [BR_MASK_W-1:0] pend_q, pend_d;
  br_arb_state_e                  state_q, state_d;
  br_tag_t                        kill_q, kill_d;

  br_tag_t                        valid_vec, mispred_vec, correct_vec, correct_sel, oldest_sel;
  br_tag_t [BR_MASK_W-1:0]        mask_vec;
  logic                           oldest_found;

  br_tag_t [NUM_BR_PORTS-1:0]     wr_tag, wr_mask;
  logic    [NUM_BR_PORTS-1:0]     wr_drop;

  always_comb begin
    valid_vec   = '0;
    mispred_vec = '0;
    mask_vec    = '0;
    for (int unsigned i = 0; i < BR_MASK_W; i++) begin
      valid_vec[i]   = pend_q[i].valid;
      mispred_vec[i] = pend_q[i].mispred;
      mask_vec[i]    = pend_q[i].mask;
    end
  end

  assign correct_vec = valid_vec & ~mispred_vec;
  // Two's-complement trick isolates the lowest-index pending correct entry.
  assign correct_sel = correct_vec & (~correct_vec + br_tag_t'(1));

  br_oldest_sel u_oldest_sel (
    .valid_i   (valid_vec),
    .mispred_i (mispred_vec),
    .mask_i    (mask_vec),
    .found_o   (oldest_found),
    .sel_o     (oldest_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kill_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = '0;
    case (state_q)
      IDLE: begin
        if (oldest_found) begin
          state_d = RECOVER;
          kill_d  = oldest_sel;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rob_br_pred_correct_o = 1'b0;
    rob_br_recovery_o     = 1'b0;
    rob_br_tag_o          = '0;
    rob_br_mask_o         = '0;
    if (state_q == IDLE) begin
      if (oldest_found) begin
        rob_br_recovery_o = 1'b1;
        rob_br_tag_o      = oldest_sel;
        for (int unsigned i = 0; i < BR_MASK_W; i++) begin
          if (oldest_sel[i]) rob_br_mask_o = rob_br_mask_o | mask_vec[i];
        end
      end else if (correct_vec != '0) begin
        rob_br_pred_correct_o = 1'b1;
        rob_br_tag_o          = correct_sel;
      end
    end
  end

  assign arb_busy_o = (valid_vec != '0) || (state_q != IDLE);

  always_comb begin
    wr_tag  = '0;
    wr_mask = '0;
    wr_drop = '0;
    for (int unsigned p = 0; p < NUM_BR_PORTS; p++) begin
      wr_tag[p]  = ex_br_tag_i[p*BR_MASK_W +: BR_MASK_W];
      wr_mask[p] = ex_br_mask_i[p*BR_MASK_W +: BR_MASK_W];
      wr_drop[p] = ((wr_mask[p] & kill_q) != '0) ||
                   (rob_br_recovery_o && ((wr_tag[p] == rob_br_tag_o) ||
                                          ((wr_mask[p] & rob_br_tag_o) != '0)));
    end
  end

  // Issue effects are applied first so that an incoming write always lands on top.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < BR_MASK_W; i++) begin
      if (rob_br_tag_o[i]) pend_d[i].valid = 1'b0;
      if (rob_br_pred_correct_o) pend_d[i].mask = pend_q[i].mask & ~rob_br_tag_o;
      if (rob_br_recovery_o && ((pend_q[i].mask & rob_br_tag_o) != '0)) pend_d[i].valid = 1'b0;
    end
    for (int unsigned p = 0; p < NUM_BR_PORTS; p++) begin
      if (ex_br_valid_i[p] && !wr_drop[p]) begin
        for (int unsigned i = 0; i < BR_MASK_W; i++) begin
          if (wr_tag[p][i]) begin
            pend_d[i].valid   = 1'b1;
            pend_d[i].mispred = ex_br_mispred_i[p];
            pend_d[i].mask    = rob_br_pred_correct_o ? (wr_mask[p] & ~rob_br_tag_o) : wr_mask[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned p = 0; p < NUM_BR_PORTS; p++) begin
        if (ex_br_valid_i[p]) begin
          assert ((wr_tag[p] & valid_vec & ~rob_br_tag_o) == '0)
            else $error("br_resolve_arb: write to pending tag %b", wr_tag[p]);
          for (int unsigned q = p + 1; q < NUM_BR_PORTS; q++) begin
            assert (!(ex_br_valid_i[q] && (wr_tag[q] == wr_tag[p])))
              else $error("br_resolve_arb: ports %0d and %0d share tag %b", p, q, wr_tag[p]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_arb.sv
// Directed and randomized checks of br_resolve_arb against a per-tag behavioural model.
module tb_br_resolve_arb;

  localparam int W = 5;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [P-1:0]   ex_br_valid_i = '0;
  logic [P*W-1:0] ex_br_tag_i = '0;
  logic [P*W-1:0] ex_br_mask_i = '0;
  logic [P-1:0]   ex_br_mispred_i = '0;
  logic           rob_br_pred_correct_o;
  logic           rob_br_recovery_o;
  logic [W-1:0]   rob_br_tag_o;
  logic [W-1:0]   rob_br_mask_o;
  logic           arb_busy_o;

  always #5 clk = ~clk;

  br_resolve_arb #(.NUM_BR_PORTS(P)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ex_br_valid_i         (ex_br_valid_i),
    .ex_br_tag_i           (ex_br_tag_i),
    .ex_br_mask_i          (ex_br_mask_i),
    .ex_br_mispred_i       (ex_br_mispred_i),
    .rob_br_pred_correct_o (rob_br_pred_correct_o),
    .rob_br_recovery_o     (rob_br_recovery_o),
    .rob_br_tag_o          (rob_br_tag_o),
    .rob_br_mask_o         (rob_br_mask_o),
    .arb_busy_o            (arb_busy_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference pending table, indexed by tag number.
  bit         mv[W];
  bit         mmp[W];
  logic [W-1:0] mk[W];
  bit         m_rec;
  logic [W-1:0] m_kill;

  // Random-phase view of in-flight branches: allocated, already presented, older-tag mask.
  bit         al[W];
  bit         res[W];
  logic [W-1:0] am[W];

  int last_kind;
  int last_idx;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // kind: 0 none, 1 correct, 2 recovery
  task automatic model_issue(output int kind, output int idx);
    bit older;
    kind = 0;
    idx  = 0;
    if (!m_rec) begin
      for (int i = 0; i < W; i++) begin
        if (kind == 0 && mv[i] && mmp[i]) begin
          older = 0;
          for (int j = 0; j < W; j++)
            if (j != i && mv[j] && mmp[j] && mk[i][j]) older = 1;
          if (!older) begin
            kind = 2;
            idx  = i;
          end
        end
      end
      for (int i = 0; i < W; i++) begin
        if (kind == 0 && mv[i] && !mmp[i]) begin
          kind = 1;
          idx  = i;
        end
      end
    end
  endtask

  task automatic check_model(output int kind, output int idx);
    logic [W-1:0] t_exp, m_exp;
    bit busy;
    model_issue(kind, idx);
    t_exp = (kind != 0) ? (W'(1) << idx) : '0;
    m_exp = (kind == 2) ? mk[idx] : '0;
    busy  = m_rec;
    for (int i = 0; i < W; i++) if (mv[i]) busy = 1;
    chk("model_correct", W'(rob_br_pred_correct_o), W'(kind == 1));
    chk("model_recovery", W'(rob_br_recovery_o), W'(kind == 2));
    chk("model_tag", rob_br_tag_o, t_exp);
    chk("model_mask", rob_br_mask_o, m_exp);
    chk("model_busy", W'(arb_busy_o), W'(busy));
  endtask

  task automatic expect_out(input string tag, input bit c, input bit r,
                            input logic [W-1:0] t, input logic [W-1:0] m, input bit b);
    chk({tag, "_correct"}, W'(rob_br_pred_correct_o), W'(c));
    chk({tag, "_recovery"}, W'(rob_br_recovery_o), W'(r));
    chk({tag, "_tag"}, rob_br_tag_o, t);
    chk({tag, "_mask"}, rob_br_mask_o, m);
    chk({tag, "_busy"}, W'(arb_busy_o), W'(b));
  endtask

  // Check current outputs, present one cycle of writes, advance the model across the edge.
  task automatic step(input logic [P-1:0] v, input logic [P*W-1:0] t,
                      input logic [P*W-1:0] m, input logic [P-1:0] mp);
    int k, idx;
    logic [W-1:0] wt, wm;
    bit drop;
    check_model(k, idx);
    ex_br_valid_i   = v;
    ex_br_tag_i     = t;
    ex_br_mask_i    = m;
    ex_br_mispred_i = mp;
    @(posedge clk);
    if (k == 1) begin
      mv[idx] = 0;
      for (int j = 0; j < W; j++) mk[j][idx] = 1'b0;
    end
    if (k == 2) begin
      mv[idx] = 0;
      for (int j = 0; j < W; j++) if (mk[j][idx]) mv[j] = 0;
    end
    for (int p = 0; p < P; p++) begin
      wt = t[p*W +: W];
      wm = m[p*W +: W];
      if (v[p]) begin
        drop = ((wm & m_kill) != '0) || (k == 2 && (wm[idx] || wt[idx]));
        if (!drop) begin
          for (int i = 0; i < W; i++) begin
            if (wt[i]) begin
              mv[i]  = 1;
              mmp[i] = mp[p];
              mk[i]  = wm;
              if (k == 1) mk[i][idx] = 1'b0;
            end
          end
        end
      end
    end
    m_rec     = (k == 2);
    m_kill    = (k == 2) ? (W'(1) << idx) : '0;
    last_kind = k;
    last_idx  = idx;
    @(negedge clk);
    ex_br_valid_i   = '0;
    ex_br_tag_i     = '0;
    ex_br_mask_i    = '0;
    ex_br_mispred_i = '0;
  endtask

  task automatic idle_step();
    step('0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    ex_br_valid_i   = '0;
    ex_br_tag_i     = '0;
    ex_br_mask_i    = '0;
    ex_br_mispred_i = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W; i++) begin
      mv[i]  = 0;
      mmp[i] = 0;
      mk[i]  = '0;
      al[i]  = 0;
      res[i] = 0;
      am[i]  = '0;
    end
    m_rec  = 0;
    m_kill = '0;
  endtask

  task automatic random_cycle();
    logic [P-1:0]   v;
    logic [P*W-1:0] t, m;
    logic [P-1:0]   mp;
    int used, c, f;
    int cands[$];
    v = '0; t = '0; m = '0; mp = '0;
    used = -1;
    for (int p = 0; p < P; p++) begin
      if ($urandom_range(9) < 6) begin
        cands.delete();
        for (int i = 0; i < W; i++) if (al[i] && !res[i] && i != used) cands.push_back(i);
        if (cands.size() > 0) begin
          c = cands[$urandom_range(cands.size() - 1)];
          v[p]         = 1'b1;
          t[p*W +: W]  = W'(1) << c;
          m[p*W +: W]  = am[c];
          mp[p]        = ($urandom_range(3) == 0);
          res[c]       = 1;
          used         = c;
        end
      end
    end
    // Late result from a squashed branch, arriving while the arbiter is recovering.
    if (m_rec && !v[1] && $urandom_range(1) == 1) begin
      f = -1;
      for (int i = 0; i < W; i++) if (!al[i] && !mv[i] && i != used) f = i;
      if (f >= 0) begin
        v[1]        = 1'b1;
        t[W +: W]   = W'(1) << f;
        m[W +: W]   = m_kill;
        mp[1]       = 1'($urandom_range(1));
      end
    end
    step(v, t, m, mp);
    if (last_kind == 1) begin
      al[last_idx] = 0;
      for (int j = 0; j < W; j++) am[j][last_idx] = 1'b0;
    end else if (last_kind == 2) begin
      al[last_idx] = 0;
      for (int j = 0; j < W; j++) if (am[j][last_idx]) al[j] = 0;
    end
    if ($urandom_range(1) == 1) begin
      cands.delete();
      for (int i = 0; i < W; i++) if (!al[i] && !mv[i]) cands.push_back(i);
      if (cands.size() > 0) begin
        c = cands[$urandom_range(cands.size() - 1)];
        am[c] = '0;
        for (int j = 0; j < W; j++) if (al[j]) am[c][j] = 1'b1;
        al[c]  = 1;
        res[c] = 0;
      end
    end
  endtask

  initial begin
    do_reset();
    expect_out("reset", 0, 0, '0, '0, 0);

    // Single correct prediction
    step(2'b01, {5'b0, 5'b00100}, {5'b0, 5'b00011}, 2'b00);
    expect_out("t1_issue", 1, 0, 5'b00100, '0, 1);
    idle_step();
    expect_out("t1_empty", 0, 0, '0, '0, 0);

    // Two correct predictions in one cycle, lowest index first
    step(2'b11, {5'b00010, 5'b00001}, {5'b00001, 5'b00000}, 2'b00);
    expect_out("t2_first", 1, 0, 5'b00001, '0, 1);
    idle_step();
    expect_out("t2_second", 1, 0, 5'b00010, '0, 1);
    idle_step();
    expect_out("t2_empty", 0, 0, '0, '0, 0);

    // Oldest mispredict recovers and squashes the younger one
    step(2'b11, {5'b01000, 5'b00010}, {5'b00011, 5'b00001}, 2'b11);
    expect_out("t3_recover", 0, 1, 5'b00010, 5'b00001, 1);
    idle_step();
    expect_out("t3_quiet", 0, 0, '0, '0, 1);

    // Writes during RECOVER: killed one dropped, legal one accepted
    step(2'b11, {5'b00100, 5'b10000}, {5'b00001, 5'b00010}, 2'b00);
    expect_out("t4_accept", 1, 0, 5'b00100, '0, 1);
    idle_step();
    expect_out("t4_drained", 0, 0, '0, '0, 0);

    // Mispredict beats a pending correct entry
    step(2'b11, {5'b00100, 5'b00001}, {5'b00001, 5'b00000}, 2'b10);
    expect_out("t5_recover", 0, 1, 5'b00100, 5'b00001, 1);
    idle_step();
    expect_out("t5_quiet", 0, 0, '0, '0, 1);
    idle_step();
    expect_out("t5_correct", 1, 0, 5'b00001, '0, 1);
    idle_step();
    expect_out("t5_empty", 0, 0, '0, '0, 0);

    // Reset while recovering with three entries pending
    step(2'b11, {5'b00010, 5'b00001}, {5'b00000, 5'b00000}, 2'b01);
    expect_out("t6_recover", 0, 1, 5'b00001, '0, 1);
    step(2'b11, {5'b01000, 5'b00100}, {5'b00000, 5'b00000}, 2'b00);
    expect_out("t6_in_recover", 0, 0, '0, '0, 1);
    do_reset();
    expect_out("t6_after_rst", 0, 0, '0, '0, 0);
    step(2'b01, {5'b0, 5'b10000}, {5'b0, 5'b0}, 2'b00);
    expect_out("t6_new", 1, 0, 5'b10000, '0, 1);
    idle_step();

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      random_cycle();
    end
    for (int n = 0; n < 12; n++) idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
